// File: rtl/uart_pkg.sv
// Shared constants for the UART debug transport: escape byte, command/address
// codes, DTMCS field layout and DMI request/response shapes.
package uart_pkg;
    localparam logic [7:0] ESC_DEFAULT = 8'hB1;

    localparam logic [2:0] CMD_NOP   = 3'd0;
    localparam logic [2:0] CMD_READ  = 3'd1;
    localparam logic [2:0] CMD_WRITE = 3'd2;
    localparam logic [2:0] CMD_RESET = 3'd3;

    localparam logic [4:0] ADDR_IDCODE = 5'h01;
    localparam logic [4:0] ADDR_DTMCS  = 5'h10;
    localparam logic [4:0] ADDR_DMI    = 5'h11;

    localparam int DTMCS_DMIRESET_BIT     = 16;
    localparam int DTMCS_DMIHARDRESET_BIT = 17;

    localparam int DMI_ABITS  = 7;
    localparam int DMI_REQ_W  = DMI_ABITS + 32 + 2;
    localparam int DMI_RESP_W = 32 + 2;

    typedef struct packed {
        logic [DMI_ABITS-1:0] addr;
        logic [31:0]          data;
        logic [1:0]           op;
    } dmi_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_resp_t;

    // {idle[14:12]=0, dmistat[11:10], abits[9:4], version[3:0]}
    function automatic logic [31:0] dtmcs_value(input logic [1:0] dmistat);
        return {17'd0, 3'd0, dmistat, 6'(DMI_ABITS), 4'd1};
    endfunction
endpackage

// File: rtl/dtm_uart_phy.sv
// 8N1 UART receiver/transmitter pair; the transmitter stays busy for one idle
// bit after each stop bit so the owner can release the line cleanly.
module dtm_uart_phy #(
    parameter int CLK_RATE  = 100_000_000,
    parameter int BAUD_RATE = 3_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_i,
    output logic       tx_o,
    output logic       rx_valid_o,
    output logic [7:0] rx_data_o,
    input  logic       tx_valid_i,
    input  logic [7:0] tx_data_i,
    output logic       tx_ready_o
);
    localparam int RATIO    = CLK_RATE / BAUD_RATE;
    localparam int BIT_CLKS = (RATIO < 4) ? 4 : RATIO;
    localparam int CW       = $clog2(BIT_CLKS);
    localparam logic [CW-1:0] CNT_BIT  = CW'(BIT_CLKS - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(BIT_CLKS / 2 - 1);

    logic [1:0]    rx_sync_q, rx_sync_d;
    logic          rx_busy_q, rx_busy_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [3:0]    rx_idx_q, rx_idx_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic          rx_valid_q, rx_valid_d;
    logic          tx_busy_q, tx_busy_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [3:0]    tx_idx_q, tx_idx_d;
    logic [10:0]   tx_shift_q, tx_shift_d;
    logic          rx_line;

    assign rx_line    = rx_sync_q[1];
    assign rx_valid_o = rx_valid_q;
    assign rx_data_o  = rx_shift_q;
    assign tx_o       = tx_shift_q[0];
    assign tx_ready_o = ~tx_busy_q;

    always_comb begin
        rx_sync_d  = {rx_sync_q[0], rx_i};
        rx_busy_d  = rx_busy_q;
        rx_cnt_d   = rx_cnt_q;
        rx_idx_d   = rx_idx_q;
        rx_shift_d = rx_shift_q;
        rx_valid_d = 1'b0;
        if (!rx_busy_q) begin
            if (!rx_line) begin
                rx_busy_d = 1'b1;
                rx_cnt_d  = CNT_HALF;
                rx_idx_d  = 4'd0;
            end
        end else if (rx_cnt_q != '0) begin
            rx_cnt_d = rx_cnt_q - CW'(1);
        end else begin
            rx_cnt_d = CNT_BIT;
            rx_idx_d = rx_idx_q + 4'd1;
            // Index 0 re-checks the start bit, 9 is the stop bit.
            if (rx_idx_q == 4'd0) begin
                if (rx_line) rx_busy_d = 1'b0;
            end else if (rx_idx_q == 4'd9) begin
                rx_busy_d  = 1'b0;
                rx_valid_d = rx_line;
            end else begin
                rx_shift_d = {rx_line, rx_shift_q[7:1]};
            end
        end
    end

    always_comb begin
        tx_busy_d  = tx_busy_q;
        tx_cnt_d   = tx_cnt_q;
        tx_idx_d   = tx_idx_q;
        tx_shift_d = tx_shift_q;
        if (!tx_busy_q) begin
            if (tx_valid_i) begin
                tx_busy_d  = 1'b1;
                tx_cnt_d   = CNT_BIT;
                tx_idx_d   = 4'd0;
                tx_shift_d = {2'b11, tx_data_i, 1'b0};
            end
        end else if (tx_cnt_q != '0) begin
            tx_cnt_d = tx_cnt_q - CW'(1);
        end else begin
            tx_cnt_d   = CNT_BIT;
            tx_shift_d = {1'b1, tx_shift_q[10:1]};
            tx_idx_d   = tx_idx_q + 4'd1;
            if (tx_idx_q == 4'd10) tx_busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync_q  <= 2'b11;
            rx_busy_q  <= 1'b0;
            rx_cnt_q   <= '0;
            rx_idx_q   <= 4'd0;
            rx_shift_q <= 8'd0;
            rx_valid_q <= 1'b0;
            tx_busy_q  <= 1'b0;
            tx_cnt_q   <= '0;
            tx_idx_q   <= 4'd0;
            tx_shift_q <= '1;
        end else begin
            rx_sync_q  <= rx_sync_d;
            rx_busy_q  <= rx_busy_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_idx_q   <= rx_idx_d;
            rx_shift_q <= rx_shift_d;
            rx_valid_q <= rx_valid_d;
            tx_busy_q  <= tx_busy_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_shift_q <= tx_shift_d;
        end
    end
endmodule

// File: rtl/dtm_uart.sv
// UART debug transport: parses escaped host commands, drives the DMI request/
// response handshake and shares the host TX line with a secondary UART.
module dtm_uart
    import uart_pkg::*;
#(
    parameter logic [7:0]  ESC               = ESC_DEFAULT,
    parameter int          CLK_RATE          = 100_000_000,
    parameter int          BAUD_RATE         = 3_000_000,
    parameter logic [31:0] IDCODE            = 32'h0000_0001,
    parameter int          STB_CONTROL_WIDTH = 8,
    parameter int          STB_STATUS_WIDTH  = 8,
    parameter int          STB_DATA_WIDTH    = 32
) (
    input  logic                        CLK_I,
    input  logic                        RST_NI,
    input  logic                        RX0_I,
    output logic                        RX1_O,
    output logic                        TX0_O,
    input  logic                        TX1_I,
    input  logic                        DMI_REQ_READY_I,
    output logic                        DMI_REQ_VALID_O,
    output logic [DMI_REQ_W-1:0]        DMI_REQ_O,
    output logic                        DMI_RESP_READY_O,
    input  logic                        DMI_RESP_VALID_I,
    input  logic [DMI_RESP_W-1:0]       DMI_RESP_I,
    input  logic                        STB0_STATUS_VALID_I,
    input  logic [STB_STATUS_WIDTH-1:0] STB0_STATUS_I,
    input  logic                        STB0_CONTROL_READY_I,
    input  logic                        STB0_DATA_VALID_I,
    input  logic [STB_DATA_WIDTH-1:0]   STB0_DATA_I,
    input  logic                        STB0_DATA_READY_I,
    input  logic                        STB1_STATUS_VALID_I,
    input  logic [STB_STATUS_WIDTH-1:0] STB1_STATUS_I,
    input  logic                        STB1_CONTROL_READY_I,
    input  logic                        STB1_DATA_VALID_I,
    input  logic [STB_DATA_WIDTH-1:0]   STB1_DATA_I,
    input  logic                        STB1_DATA_READY_I
);
    localparam logic [1:0] ST_IDLE = 2'd0, ST_CMD = 2'd1, ST_PAYLOAD = 2'd2, ST_SEND = 2'd3;
    localparam int UNUSED_CTRL_W = STB_CONTROL_WIDTH;

    logic [1:0]            state_q, state_d;
    logic                  esc_seen_q, esc_seen_d;
    logic [4:0]            addr_q, addr_d;
    logic [2:0]            pay_cnt_q, pay_cnt_d, pay_len_q, pay_len_d;
    logic [47:0]           payload_q, payload_d;
    logic [39:0]           reply_q, reply_d;
    logic [2:0]            reply_len_q, reply_len_d, reply_idx_q, reply_idx_d;
    logic                  dup_q, dup_d, owner_q, owner_d;
    logic [DMI_REQ_W-1:0]  req_q, req_d;
    logic                  req_valid_q, req_valid_d, resp_ready_q, resp_ready_d;
    logic [DMI_RESP_W-1:0] resp_q, resp_d;
    logic [1:0]            dmistat_q, dmistat_d;

    logic       rx_valid, tx_ready, tx_valid, phy_tx;
    logic [7:0] rx_byte, tx_byte;
    logic       decode_now, data_now;
    logic       unused_stb;

    assign unused_stb = ^{STB0_STATUS_VALID_I, STB0_STATUS_I, STB0_CONTROL_READY_I, STB0_DATA_VALID_I,
                          STB0_DATA_I, STB0_DATA_READY_I, STB1_STATUS_VALID_I, STB1_STATUS_I,
                          STB1_CONTROL_READY_I, STB1_DATA_VALID_I, STB1_DATA_I, STB1_DATA_READY_I,
                          UNUSED_CTRL_W[0]};

    dtm_uart_phy #(.CLK_RATE(CLK_RATE), .BAUD_RATE(BAUD_RATE)) u_phy (
        .clk(CLK_I), .rst_n(RST_NI), .rx_i(RX0_I), .tx_o(phy_tx),
        .rx_valid_o(rx_valid), .rx_data_o(rx_byte),
        .tx_valid_i(tx_valid), .tx_data_i(tx_byte), .tx_ready_o(tx_ready)
    );

    assign RX1_O            = RX0_I;
    assign TX0_O            = owner_q ? phy_tx : TX1_I;
    assign DMI_REQ_O        = req_q;
    assign DMI_REQ_VALID_O  = req_valid_q;
    assign DMI_RESP_READY_O = resp_ready_q;

    assign tx_byte  = reply_q[{reply_idx_q, 3'b000} +: 8];
    assign tx_valid = (state_q == ST_SEND) && owner_q && (reply_idx_q != reply_len_q);
    // A non-ESC byte after ESC inside a payload aborts the write and is itself a command.
    assign decode_now = rx_valid && (rx_byte != ESC) &&
                        ((state_q == ST_CMD) || ((state_q == ST_PAYLOAD) && esc_seen_q));
    assign data_now   = rx_valid && (state_q == ST_PAYLOAD) &&
                        (esc_seen_q ? (rx_byte == ESC) : (rx_byte != ESC));

    always_comb begin
        state_d = state_q; esc_seen_d = esc_seen_q; addr_d = addr_q;
        pay_cnt_d = pay_cnt_q; pay_len_d = pay_len_q; payload_d = payload_q;
        reply_d = reply_q; reply_len_d = reply_len_q; reply_idx_d = reply_idx_q;
        dup_d = dup_q; owner_d = owner_q; req_d = req_q;
        req_valid_d = req_valid_q; resp_ready_d = resp_ready_q;
        resp_d = resp_q; dmistat_d = dmistat_q;

        if (req_valid_q && DMI_REQ_READY_I) begin
            req_valid_d  = 1'b0;
            resp_ready_d = 1'b1;
        end
        if (resp_ready_q && DMI_RESP_VALID_I) begin
            resp_d       = DMI_RESP_I;
            resp_ready_d = 1'b0;
        end

        if (rx_valid && (state_q == ST_IDLE) && (rx_byte == ESC)) state_d = ST_CMD;
        if (rx_valid && (state_q == ST_CMD) && (rx_byte == ESC)) state_d = ST_IDLE;
        if (rx_valid && (state_q == ST_PAYLOAD) && !esc_seen_q && (rx_byte == ESC)) esc_seen_d = 1'b1;

        if (decode_now) begin
            esc_seen_d = 1'b0;
            state_d    = ST_IDLE;
            case (rx_byte[7:5])
                CMD_READ: begin
                    reply_idx_d = 3'd0;
                    dup_d       = 1'b0;
                    reply_len_d = 3'd4;
                    state_d     = ST_SEND;
                    case (rx_byte[4:0])
                        ADDR_IDCODE: reply_d = {8'd0, IDCODE};
                        ADDR_DTMCS:  reply_d = {8'd0, dtmcs_value(dmistat_q)};
                        ADDR_DMI: begin
                            reply_d     = {6'd0, resp_q};
                            reply_len_d = 3'd5;
                        end
                        default:     state_d = ST_IDLE;
                    endcase
                end
                CMD_WRITE: begin
                    if ((rx_byte[4:0] == ADDR_IDCODE) || (rx_byte[4:0] == ADDR_DTMCS) ||
                        (rx_byte[4:0] == ADDR_DMI)) begin
                        addr_d    = rx_byte[4:0];
                        pay_cnt_d = 3'd0;
                        pay_len_d = (rx_byte[4:0] == ADDR_DMI) ? 3'd6 : 3'd4;
                        payload_d = 48'd0;
                        state_d   = ST_PAYLOAD;
                    end
                end
                CMD_RESET: begin
                    req_valid_d  = 1'b0;
                    resp_ready_d = 1'b0;
                    dmistat_d    = 2'd0;
                end
                default: ;
            endcase
        end

        if (data_now) begin
            esc_seen_d = 1'b0;
            payload_d[{pay_cnt_q, 3'b000} +: 8] = rx_byte;
            pay_cnt_d = pay_cnt_q + 3'd1;
            if (pay_cnt_q == pay_len_q - 3'd1) begin
                state_d = ST_IDLE;
                if (addr_q == ADDR_DTMCS) begin
                    if (payload_d[DTMCS_DMIRESET_BIT] || payload_d[DTMCS_DMIHARDRESET_BIT])
                        dmistat_d = 2'd0;
                    if (payload_d[DTMCS_DMIHARDRESET_BIT]) begin
                        req_valid_d  = 1'b0;
                        resp_ready_d = 1'b0;
                    end
                end else if (addr_q == ADDR_DMI) begin
                    if (req_valid_q || resp_ready_q) begin
                        dmistat_d = 2'd3;
                    end else begin
                        req_d       = payload_d[DMI_REQ_W-1:0];
                        req_valid_d = 1'b1;
                    end
                end
            end
        end

        // The line is claimed only while the secondary UART idles high.
        if (state_q == ST_SEND) begin
            if (!owner_q) begin
                if (TX1_I && tx_ready) owner_d = 1'b1;
            end else if (tx_valid && tx_ready) begin
                if ((tx_byte == ESC) && !dup_q) begin
                    dup_d = 1'b1;
                end else begin
                    dup_d       = 1'b0;
                    reply_idx_d = reply_idx_q + 3'd1;
                end
            end else if ((reply_idx_q == reply_len_q) && tx_ready) begin
                owner_d = 1'b0;
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            state_q <= ST_IDLE; esc_seen_q <= 1'b0; addr_q <= 5'd0;
            pay_cnt_q <= 3'd0; pay_len_q <= 3'd0; payload_q <= 48'd0;
            reply_q <= 40'd0; reply_len_q <= 3'd0; reply_idx_q <= 3'd0;
            dup_q <= 1'b0; owner_q <= 1'b0; req_q <= '0;
            req_valid_q <= 1'b0; resp_ready_q <= 1'b0;
            resp_q <= '0; dmistat_q <= 2'd0;
        end else begin
            state_q <= state_d; esc_seen_q <= esc_seen_d; addr_q <= addr_d;
            pay_cnt_q <= pay_cnt_d; pay_len_q <= pay_len_d; payload_q <= payload_d;
            reply_q <= reply_d; reply_len_q <= reply_len_d; reply_idx_q <= reply_idx_d;
            dup_q <= dup_d; owner_q <= owner_d; req_q <= req_d;
            req_valid_q <= req_valid_d; resp_ready_q <= resp_ready_d;
            resp_q <= resp_d; dmistat_q <= dmistat_d;
        end
    end
endmodule

// File: tb/tb_dtm_uart.sv
// Scoreboard bench for dtm_uart: host bytes in, expected reply bytes and DMI
// requests queued, independent monitors decode TX0 and act as dm_top.
module tb_dtm_uart;
    localparam int BIT = 16;
    localparam logic [7:0] ESC = 8'hB1;

    logic        clk = 1'b0, rst_n = 1'b0, rx0 = 1'b1, tx1 = 1'b1;
    logic        req_ready = 1'b1, resp_valid = 1'b0;
    logic [33:0] resp = 34'd0;
    logic        rx1, tx0, req_valid, resp_ready;
    logic [40:0] req;

    int          n_cmp = 0, n_err = 0, tx_seen = 0;
    logic [7:0]  exp_tx[$];
    logic [40:0] exp_req[$];
    bit          mon_en = 1'b1;
    logic [31:0] dm_mem[128];

    dtm_uart #(.CLK_RATE(BIT * 100), .BAUD_RATE(100)) dut (
        .CLK_I(clk), .RST_NI(rst_n), .RX0_I(rx0), .RX1_O(rx1), .TX0_O(tx0), .TX1_I(tx1),
        .DMI_REQ_READY_I(req_ready), .DMI_REQ_VALID_O(req_valid), .DMI_REQ_O(req),
        .DMI_RESP_READY_O(resp_ready), .DMI_RESP_VALID_I(resp_valid), .DMI_RESP_I(resp),
        .STB0_STATUS_VALID_I(1'b0), .STB0_STATUS_I(8'd0), .STB0_CONTROL_READY_I(1'b0),
        .STB0_DATA_VALID_I(1'b0), .STB0_DATA_I(32'd0), .STB0_DATA_READY_I(1'b0),
        .STB1_STATUS_VALID_I(1'b0), .STB1_STATUS_I(8'd0), .STB1_CONTROL_READY_I(1'b0),
        .STB1_DATA_VALID_I(1'b0), .STB1_DATA_I(32'd0), .STB1_DATA_READY_I(1'b0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
        rx0 = 1'b0; repeat (BIT) @(posedge clk);
        for (int i = 0; i < 8; i++) begin rx0 = b[i]; repeat (BIT) @(posedge clk); end
        rx0 = stop; repeat (BIT) @(posedge clk);
        rx0 = 1'b1;
        if (!stop) repeat (2 * BIT) @(posedge clk);
    endtask

    task automatic cmd(input logic [7:0] c);
        send_byte(ESC);
        send_byte(c);
    endtask

    task automatic send_payload(input logic [47:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            send_byte(v[8*i +: 8]);
            if (v[8*i +: 8] == ESC) send_byte(ESC);
        end
    endtask

    task automatic expect_tx(input logic [7:0] b0, b1, b2, b3);
        exp_tx.push_back(b0); exp_tx.push_back(b1); exp_tx.push_back(b2); exp_tx.push_back(b3);
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        while (exp_tx.size() != 0 && t < 80 * BIT) begin @(posedge clk); t++; end
        chk(name, 64'(exp_tx.size()), 64'd0);
        repeat (3 * BIT) @(posedge clk);
    endtask

    task automatic wait_req(input string name);
        int t = 0;
        while (exp_req.size() != 0 && t < 40 * BIT) begin @(posedge clk); t++; end
        chk(name, 64'(exp_req.size()), 64'd0);
        repeat (8) @(posedge clk);
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk); #1 req_ready = v;
    endtask

    // TX0 byte monitor
    initial begin : tx_mon
        logic [7:0] b;
        logic       stop;
        logic [7:0] e;
        forever begin
            @(negedge tx0);
            if (mon_en) begin
                repeat (BIT / 2) @(posedge clk);
                for (int i = 0; i < 8; i++) begin repeat (BIT) @(posedge clk); #1 b[i] = tx0; end
                repeat (BIT) @(posedge clk); #1 stop = tx0;
                if (mon_en) begin
                    tx_seen++;
                    n_cmp++;
                    if (exp_tx.size() == 0) begin
                        n_err++;
                        $display("FAIL tx_byte: got unexpected byte %02h", b);
                    end else begin
                        e = exp_tx.pop_front();
                        if (b !== e || stop !== 1'b1) begin
                            n_err++;
                            $display("FAIL tx_byte: got %02h stop %0b expected %02h stop 1", b, stop, e);
                        end else begin
                            $display("tx byte %02h", b);
                        end
                    end
                end
            end
        end
    end

    // dm_top stand-in: checks each accepted request, answers one response later
    initial begin : dm_model
        logic        pend;
        logic [33:0] pend_resp;
        logic [40:0] e;
        pend = 1'b0;
        pend_resp = 34'd0;
        for (int i = 0; i < 128; i++) dm_mem[i] = 32'd0;
        forever begin
            @(negedge clk);
            if (resp_valid && !resp_ready) resp_valid = 1'b0;
            else if (pend && resp_ready && !resp_valid) begin
                resp_valid = 1'b1; resp = pend_resp; pend = 1'b0;
            end
            if (req_valid && req_ready) begin
                n_cmp++;
                if (exp_req.size() == 0) begin
                    n_err++;
                    $display("FAIL dmi_req: got unexpected request %011h", req);
                end else begin
                    e = exp_req.pop_front();
                    if (req !== e) begin
                        n_err++;
                        $display("FAIL dmi_req: got %011h expected %011h", req, e);
                    end else begin
                        $display("dmi req addr %02h data %08h op %0d", req[40:34], req[33:2], req[1:0]);
                    end
                end
                if (req[1:0] == 2'd2) begin
                    dm_mem[req[40:34]] = req[33:2];
                    pend_resp = 34'd0;
                end else begin
                    pend_resp = {dm_mem[req[40:34]], 2'd0};
                end
                pend = 1'b1;
            end
        end
    end

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int t;
        int seen0;
        repeat (3) @(posedge clk); #1;
        chk("reset_tx0", 64'(tx0), 64'd1);
        chk("reset_req_valid", 64'(req_valid), 64'd0);
        chk("reset_req", 64'(req), 64'd0);
        chk("reset_resp_ready", 64'(resp_ready), 64'd0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);

        expect_tx(8'h01, 8'h00, 8'h00, 8'h00);
        cmd(8'h21); wait_drain("idcode_read");

        expect_tx(8'h71, 8'h00, 8'h00, 8'h00);
        cmd(8'h30); wait_drain("dtmcs_read");

        exp_req.push_back(41'h040_0000_0006);
        cmd(8'h51); send_payload(48'hFC40_0000_0006, 6); wait_req("dmi_write_dmactive");

        exp_req.push_back(41'h040_0000_0005);
        cmd(8'h51); send_payload(48'hFC40_0000_0005, 6); wait_req("dmi_read_dmcontrol");

        expect_tx(8'h04, 8'h00, 8'h00, 8'h00); exp_tx.push_back(8'h00);
        cmd(8'h31); wait_drain("dmi_resp_read");

        // busy: first request held pending, second one discarded
        set_ready(1'b0);
        exp_req.push_back(41'h040_0000_0006);
        cmd(8'h51); send_payload(48'hFC40_0000_0006, 6);
        cmd(8'h51); send_payload(48'hFC40_0000_0006, 6);
        expect_tx(8'h71, 8'h0C, 8'h00, 8'h00);
        cmd(8'h30); wait_drain("dtmcs_busy");
        cmd(8'h50); send_payload(48'h0000_0001_0000, 4);
        expect_tx(8'h71, 8'h00, 8'h00, 8'h00);
        cmd(8'h30); wait_drain("dtmcs_after_dmireset");
        set_ready(1'b1);
        wait_req("busy_first_req");

        // ESC inside payload and inside reply
        exp_req.push_back(41'h010_0000_B102);
        cmd(8'h51); send_payload(48'h0010_0000_B102, 6); wait_req("dmi_write_esc_payload");
        exp_req.push_back(41'h010_0000_0001);
        cmd(8'h51); send_payload(48'h0010_0000_0001, 6); wait_req("dmi_read_data0");
        expect_tx(8'h00, 8'hB1, 8'hB1, 8'h00); exp_tx.push_back(8'h00); exp_tx.push_back(8'h00);
        cmd(8'h31); wait_drain("dmi_resp_esc_doubled");

        // framing error on ESC drops it; the following 0x21 is plain data
        seen0 = tx_seen;
        send_byte(ESC, 1'b0); send_byte(8'h21);
        repeat (30 * BIT) @(posedge clk);
        chk("framing_drop", 64'(tx_seen - seen0), 64'd0);

        // passthrough with no DTM traffic
        mon_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1 tx1 = i[0]; rx0 = i[1] | i[0];
            #1;
            chk("pass_tx0", 64'(tx0), 64'(i[0]));
            chk("pass_rx1", 64'(rx1), 64'(i[1] | i[0]));
        end
        @(posedge clk); #1 tx1 = 1'b1; rx0 = 1'b1;
        repeat (12 * BIT) @(posedge clk);
        mon_en = 1'b1;

        // reset mid-reply with a request outstanding
        set_ready(1'b0);
        cmd(8'h51); send_payload(48'hFC40_0000_0006, 6);
        repeat (5) @(posedge clk); #1;
        chk("pending_before_reset", 64'(req_valid), 64'd1);
        expect_tx(8'h01, 8'h00, 8'h00, 8'h00);
        cmd(8'h21);
        t = 0;
        while (tx0 !== 1'b0 && t < 20 * BIT) begin @(posedge clk); #1; t++; end
        chk("reply_started", 64'(tx0), 64'd0);
        repeat (3 * BIT) @(posedge clk);
        mon_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_tx0", 64'(tx0), 64'd1);
        chk("midreset_req_valid", 64'(req_valid), 64'd0);
        chk("midreset_resp_ready", 64'(resp_ready), 64'd0);
        exp_tx.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        set_ready(1'b1);
        repeat (12 * BIT) @(posedge clk);
        mon_en = 1'b1;

        expect_tx(8'h71, 8'h00, 8'h00, 8'h00);
        cmd(8'h30); wait_drain("dtmcs_after_reset");

        chk("req_queue_empty", 64'(exp_req.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
